pc_fetch_ctrl: RTL and testbench

- Parametrised program-counter and fetch-request controller for the pipelined core. It replaces the plain start-gated PC register.
- Generates the IF-stage fetch address and a valid/ready request to instruction memory.
- Holds on a hazard stall and applies branch/jump redirects from ID.
- Buffers a redirect that arrives while stalled or idle, counts accepted fetches, and halts on a misaligned redirect target.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_redirect_buf.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter / fetch-request controller.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  // True when the low align_bits bits of addr are all zero.
  function automatic logic is_aligned(input logic [63:0] addr,
                                      input int unsigned align_bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < align_bits) && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry holding register for a redirect target that could not be
// applied immediately (core stalled or idle).
module pc_redirect_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] target_i,
  output logic            valid_o,
  output logic [XLEN-1:0] target_o
);

  logic            valid_q;
  logic [XLEN-1:0] target_q;

  // Load overwrites any older entry; clear empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      target_q <= target_i;
    end else if (clear_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request controller for the IF stage.
// Handles hazard stalls, branch/jump redirects from ID, buffering of redirects
// that arrive while stalled or idle, fetch counting and misalignment halt.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             imem_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             fetch_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  pc_state_e        state_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             tgt_aligned;
  logic             buf_load;
  logic             buf_clear;
  logic             pend_valid;
  logic [XLEN-1:0]  pend_target;

  assign tgt_aligned = is_aligned(64'(redirect_pc_i), ALIGN_BITS);

  assign fetch_valid_o = (state_q == RUN) && !stall_i;
  assign misalign_o    = (state_q == HALT);
  assign pc_o          = pc_q;
  assign fetch_cnt_o   = cnt_q;

  pc_redirect_buf #(
    .XLEN (XLEN)
  ) u_redirect_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (buf_load),
    .clear_i  (buf_clear),
    .target_i (redirect_pc_i),
    .valid_o  (pend_valid),
    .target_o (pend_target)
  );

  // Pending-buffer control, following the same priority as the PC update.
  always_comb begin
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      IDLE: buf_load = redirect_valid_i && tgt_aligned;
      RUN: begin
        if (!start_i)                             buf_load  = redirect_valid_i && tgt_aligned;
        else if (redirect_valid_i && !tgt_aligned) buf_load  = 1'b0;
        else if (redirect_valid_i && !stall_i)     buf_clear = 1'b1;
        else if (redirect_valid_i)                 buf_load  = 1'b1;
        else if (!stall_i && pend_valid)           buf_clear = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM and PC register: one prioritised action per edge in RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= RUN;
        end
        RUN: begin
          if (!start_i) begin
            state_q <= IDLE;
          end else if (redirect_valid_i && !tgt_aligned) begin
            // Raw faulting target is kept in the PC for debug.
            state_q <= HALT;
            pc_q    <= redirect_pc_i;
          end else if (redirect_valid_i && !stall_i) begin
            pc_q <= redirect_pc_i;
          end else if (redirect_valid_i) begin
            pc_q <= pc_q;
          end else if (!stall_i && pend_valid) begin
            pc_q <= pend_target;
          end else if (!stall_i && imem_ready_i) begin
            pc_q <= pc_q + XLEN'(INC);
          end
        end
        default: ;
      endcase
    end
  end

  // Accepted-fetch counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (fetch_valid_o && imem_ready_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_pc_fetch_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        misalign_o;
  logic [3:0]  fetch_cnt_o;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state.
  logic        m_run;
  logic        m_halt;
  logic        m_pv;
  logic [31:0] m_pend;
  logic [31:0] m_pc;
  int unsigned m_cnt;

  pc_fetch_ctrl #(
    .XLEN       (32),
    .RESET_VEC  (32'h0000_0100),
    .INC        (4),
    .ALIGN_BITS (2),
    .CNT_W      (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_ready_i     (imem_ready_i),
    .pc_o             (pc_o),
    .fetch_valid_o    (fetch_valid_o),
    .misalign_o       (misalign_o),
    .fetch_cnt_o      (fetch_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_pv   = 1'b0;
    m_pend = 32'h0;
    m_pc   = 32'h0000_0100;
    m_cnt  = 0;
  endtask

  // Apply the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    logic ok;
    ok = (redirect_pc_i[1:0] == 2'b00);
    if (m_halt) return;
    if (m_run && !stall_i && imem_ready_i) m_cnt = (m_cnt + 1) % 16;
    if (!m_run) begin
      if (redirect_valid_i && ok) begin m_pend = redirect_pc_i; m_pv = 1'b1; end
      if (start_i) m_run = 1'b1;
    end else if (!start_i) begin
      m_run = 1'b0;
      if (redirect_valid_i && ok) begin m_pend = redirect_pc_i; m_pv = 1'b1; end
    end else if (redirect_valid_i && !ok) begin
      m_run  = 1'b0;
      m_halt = 1'b1;
      m_pc   = redirect_pc_i;
    end else if (redirect_valid_i && !stall_i) begin
      m_pc = redirect_pc_i;
      m_pv = 1'b0;
    end else if (redirect_valid_i) begin
      m_pend = redirect_pc_i;
      m_pv   = 1'b1;
    end else if (!stall_i && m_pv) begin
      m_pc = m_pend;
      m_pv = 1'b0;
    end else if (!stall_i && imem_ready_i) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One cycle: drive, check the request mid-cycle, clock, check the state.
  task automatic step(input logic st, input logic sl, input logic rv,
                      input logic [31:0] rpc, input logic rd);
    start_i          = st;
    stall_i          = sl;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    imem_ready_i     = rd;
    #4;
    chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, (m_run && !sl)});
    model_edge();
    @(posedge clk_i);
    #1;
    chk("pc", pc_o, m_pc);
    chk("misalign", {31'b0, misalign_o}, {31'b0, m_halt});
    chk("fetch_cnt", {28'b0, fetch_cnt_o}, 32'(m_cnt));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    start_i          = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    imem_ready_i     = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_pc", pc_o, 32'h0000_0100);
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst_cnt", {28'b0, fetch_cnt_o}, 32'h0);
    chk("rst_fetch_valid", {31'b0, fetch_valid_o}, 32'h0);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int unsigned halted;
    logic [31:0] tgt;
    n_vec = 0;
    n_err = 0;
    rst_i = 1'b1;
    start_i = 1'b0;
    stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 32'h0;
    imem_ready_i = 1'b0;
    model_reset();
    #1;
    chk("reset_pc", pc_o, 32'h0000_0100);
    chk("reset_cnt", {28'b0, fetch_cnt_o}, 32'h0);
    chk("reset_misalign", {31'b0, misalign_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Start from reset: one idle edge, then sequential fetches.
    step(1, 0, 0, 32'h0, 1);
    chk("start_pc", pc_o, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 1);
    chk("seq_pc", pc_o, 32'h0000_0110);
    chk("seq_cnt", {28'b0, fetch_cnt_o}, 32'd4);

    // Stall with a redirect in the middle of it.
    step(1, 0, 1, 32'h200, 1);
    chk("redir_pc", pc_o, 32'h200);
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 32'h400, 1);
    step(1, 1, 0, 32'h0, 1);
    chk("stall_hold_pc", pc_o, 32'h200);
    chk("stall_cnt", {28'b0, fetch_cnt_o}, 32'd5);
    step(1, 0, 0, 32'h0, 1);
    chk("pend_apply", pc_o, 32'h400);
    step(1, 0, 0, 32'h0, 1);
    chk("pend_next", pc_o, 32'h404);

    // Stall release coinciding with a fresh redirect drops the pending one.
    step(1, 1, 1, 32'h400, 1);
    step(1, 0, 1, 32'h800, 1);
    chk("new_redir_wins", pc_o, 32'h800);
    step(1, 0, 0, 32'h0, 1);
    chk("after_new_redir", pc_o, 32'h804);

    // Memory back-pressure.
    step(1, 0, 1, 32'h10, 1);
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    chk("not_ready_hold", pc_o, 32'h10);
    step(1, 0, 0, 32'h0, 1);
    chk("ready_again", pc_o, 32'h14);

    // PC wrap at the top of the address space.
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("pc_wrap", pc_o, 32'h0);

    // Misaligned redirect halts; inputs then ignored until reset.
    step(1, 0, 1, 32'h302, 1);
    chk("halt_pc", pc_o, 32'h302);
    chk("halt_flag", {31'b0, misalign_o}, 32'h1);
    step(0, 0, 1, 32'h500, 1);
    step(1, 0, 1, 32'h600, 1);
    step(1, 1, 0, 32'h0, 0);
    chk("halt_sticky_pc", pc_o, 32'h302);
    async_reset();

    // Counter wraps after 16 accepted fetches from reset.
    for (int i = 0; i < 17; i++) step(1, 0, 0, 32'h0, 1);
    chk("cnt_wrap", {28'b0, fetch_cnt_o}, 32'h0);

    // Randomized traffic.
    halted = 0;
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 29) == 0) tgt[1:0] = 2'(1 + $urandom_range(0, 2));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, tgt, $urandom_range(0, 3) != 0);
      if (m_halt) halted++;
      if (halted > 3) begin
        async_reset();
        halted = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
